id_hazard_stage: RTL and testbench
==================================

# id_hazard_stage

Parametrised decode-operand stage with ID/EX pipeline register. Resolves both source operands from the register file or from up to NUM_FWD forwarding sources, detects load-use hazards and inserts bubbles. Handles branch flush and counts stall cycles. Sits between the IF/ID register and EX, replacing the purely combinational operand selection of the current decoder with a valid/ready-handshaked registered stage.

## Interface
Parameters:
- DATA_W, 16, datapath width (operands, PC, immediates)
- RADDR_W, 4, register address width (general regs plus SP, T, IH)
- CTRL_W, 8, opaque decoded control bundle (alusel/aluop), passed through
- NUM_FWD, 2, forwarding sources; index 0 = youngest (EX), highest priority
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  DATA_W  instruction PC
- in_rs0_re, in_rs1_re  in  1 each  operand read enables
- in_rs0_addr, in_rs1_addr  in  RADDR_W each  source addresses
- rf_data0, rf_data1  in  DATA_W each  register file read data for in_rs0_addr/in_rs1_addr
- in_imm  in  DATA_W  extended immediate
- in_we  in  1  destination write enable
- in_waddr  in  RADDR_W  destination address
- in_is_load  in  1  instruction is a memory load
- in_ctrl  in  CTRL_W  decoded control
- fwd_we  in  NUM_FWD  per-source write enable
- fwd_pending  in  NUM_FWD  per-source result not yet available (load in flight)
- fwd_waddr  in  NUM_FWD*RADDR_W  packed, source i at [i*RADDR_W +: RADDR_W]
- fwd_wdata  in  NUM_FWD*DATA_W  packed likewise
- flush  in  1  branch redirect; kill ID and ID/EX contents
- out_valid  out  1  ID/EX holds valid instruction
- out_ready  in  1  EX accepts
- out_pc, out_op0, out_op1  out  DATA_W  registered PC and operands
- out_we, out_is_load  out  1  registered
- out_waddr  out  RADDR_W  registered
- out_ctrl  out  CTRL_W  registered
- stall_req  out  1  load-use stall this cycle (to PC/IF)
- stall_cnt  out  CNT_W  saturating stall-cycle count

## Operation
- Operand resolution per operand k (combinational): if rsk_re=0, op0 = in_pc, op1 = in_imm. Otherwise the lowest index i with fwd_we[i] and matching fwd_waddr[i] selects fwd_wdata[i]; if there is no match, rf_datak is used. No hardwired zero register; address 0 forwards normally.
- Hazard: an operand with rsk_re=1 whose selected (highest-priority) matching source has fwd_pending=1. A lower-priority non-pending match does not mask a pending younger one.
- stall_req = in_valid & hazard & ~flush.
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- fire = in_valid & in_ready. On fire, all out_* are loaded from inputs and resolved operands, and out_valid<=1.
- If not fire, out_ready=1 and flush=0: out_valid<=0 (bubble). Other out_* fields hold their values.
- If out_ready=0 and flush=0: all out_* hold (backpressure), regardless of hazard.
- flush=1: out_valid<=0 and in_ready=0. It overrides fire, backpressure and hazard. Upstream discards its own contents.
- stall_cnt increments by 1 on each cycle with stall_req=1. It saturates at all-ones and is never cleared except by rst.
- rst: out_valid, out_we, out_is_load <= 0. out_pc, out_op0, out_op1, out_waddr, out_ctrl <= 0. stall_cnt <= 0. Takes effect immediately and asynchronously, mid-transfer included.

## Timing
- Latency: 1 cycle from fire to out_valid with data.
- Throughput: 1 instruction/cycle with no hazard and out_ready=1.
- Load-use: in_ready stays low while the matching pending bit is set. Acceptance happens in the first cycle the pending bit drops, forwarding that cycle's fwd_wdata.
- in_ready, stall_req: combinational from inputs and out_valid; no combinational path from in_valid to in_ready.
- out_* are driven only from flops.

## Structure
- Shared defines file holds the constants RstEnable, ReadEnable, WriteEnable, ZeroWord and the special register addresses (SP, T, IH).
- One sub-module, id_fwd_mux, is instantiated twice. It is a parametrised priority mux over NUM_FWD sources plus the RF default, and outputs data and a hazard bit.
- Top level holds the handshake, the ID/EX register and stall_cnt.

## Test plan
- Forward priority: rs0=R3, fwd0 writes R3=0x1111, fwd1 writes R3=0x2222 -> out_op0=0x1111 one cycle after fire.
- Load-use: rs1=R5, fwd0 we=1, pending=1, addr=R5 for 2 cycles, then pending=0 with data 0xBEEF:
  - stall_req=1 and in_ready=0 for 2 cycles; out_valid=0 during those cycles.
  - Then out_op1=0xBEEF; stall_cnt=2.
- Immediate and PC paths: rs0_re=rs1_re=0, in_pc=0x0040, in_imm=0xFFF8 -> out_op0=0x0040, out_op1=0xFFF8 regardless of forwarding inputs.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable. After out_ready=1, the next instruction is accepted the same cycle.
- Flush vs fire: flush=1 with in_valid=1 and no hazard -> in_ready=0, next cycle out_valid=0. Async rst mid-stall -> all outputs 0 and stall_cnt=0 immediately.
- Saturation: with CNT_W=4, hold a hazard for 20 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/id_hazard_stage_pkg.sv
// id_hazard_stage_pkg: shared constants for the decode-operand / hazard stage
package id_hazard_stage_pkg;
    localparam logic        RstEnable   = 1'b1;
    localparam logic        ReadEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [15:0] ZeroWord    = 16'h0000;
    localparam logic [3:0]  RegSP       = 4'd8;
    localparam logic [3:0]  RegT        = 4'd9;
    localparam logic [3:0]  RegIH       = 4'd10;
endpackage

// File: rtl/id_hazard_stage_if.sv
// id_hazard_stage_if: decode-side, forwarding and ID/EX-side signals of the hazard stage
interface id_hazard_stage_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int CTRL_W  = 8,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_pc;
    logic                        in_rs0_re;
    logic                        in_rs1_re;
    logic [RADDR_W-1:0]          in_rs0_addr;
    logic [RADDR_W-1:0]          in_rs1_addr;
    logic [DATA_W-1:0]           rf_data0;
    logic [DATA_W-1:0]           rf_data1;
    logic [DATA_W-1:0]           in_imm;
    logic                        in_we;
    logic [RADDR_W-1:0]          in_waddr;
    logic                        in_is_load;
    logic [CTRL_W-1:0]           in_ctrl;
    logic [NUM_FWD-1:0]          fwd_we;
    logic [NUM_FWD-1:0]          fwd_pending;
    logic [NUM_FWD*RADDR_W-1:0]  fwd_waddr;
    logic [NUM_FWD*DATA_W-1:0]   fwd_wdata;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_pc;
    logic [DATA_W-1:0]           out_op0;
    logic [DATA_W-1:0]           out_op1;
    logic                        out_we;
    logic                        out_is_load;
    logic [RADDR_W-1:0]          out_waddr;
    logic [CTRL_W-1:0]           out_ctrl;
    logic                        stall_req;
    logic [CNT_W-1:0]            stall_cnt;

    modport master (
        output in_valid, in_pc, in_rs0_re, in_rs1_re, in_rs0_addr, in_rs1_addr,
               rf_data0, rf_data1, in_imm, in_we, in_waddr, in_is_load, in_ctrl,
               fwd_we, fwd_pending, fwd_waddr, fwd_wdata, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_op0, out_op1, out_we, out_is_load,
               out_waddr, out_ctrl, stall_req, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_rs0_re, in_rs1_re, in_rs0_addr, in_rs1_addr,
               rf_data0, rf_data1, in_imm, in_we, in_waddr, in_is_load, in_ctrl,
               fwd_we, fwd_pending, fwd_waddr, fwd_wdata, flush, out_ready,
        output in_ready, out_valid, out_pc, out_op0, out_op1, out_we, out_is_load,
               out_waddr, out_ctrl, stall_req, stall_cnt
    );
endinterface

// File: rtl/id_hazard_stage_fwd_mux.sv
// id_fwd_mux: priority operand mux over forwarding sources with RF fallback and pending-hazard flag
module id_fwd_mux
    import id_hazard_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int NUM_FWD = 2
) (
    input  logic                       re_i,
    input  logic [RADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]          rf_data_i,
    input  logic [DATA_W-1:0]          alt_data_i,
    input  logic [NUM_FWD-1:0]         fwd_we_i,
    input  logic [NUM_FWD-1:0]         fwd_pending_i,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       hazard_o
);
    // Scan oldest to youngest so the lowest-index match overwrites; the pending bit follows the winner only
    always_comb begin
        data_o   = rf_data_i;
        hazard_o = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_we_i[i] == WriteEnable && fwd_waddr_i[i*RADDR_W +: RADDR_W] == addr_i) begin
                data_o   = fwd_wdata_i[i*DATA_W +: DATA_W];
                hazard_o = fwd_pending_i[i];
            end
        end
        if (re_i != ReadEnable) begin
            data_o   = alt_data_i;
            hazard_o = 1'b0;
        end
    end
endmodule

// File: rtl/id_hazard_stage.sv
// id_hazard_stage: operand resolution, load-use stall, flush and handshaked ID/EX register
module id_hazard_stage
    import id_hazard_stage_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int CTRL_W  = 8,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst,
    id_hazard_stage_if.slave bus
);
    logic [DATA_W-1:0]  op0, op1;
    logic               haz0, haz1, hazard, in_ready, fire, stall_req;
    logic               out_valid_q, out_valid_d, out_we_q, out_we_d, out_is_load_q, out_is_load_d;
    logic [DATA_W-1:0]  out_pc_q, out_pc_d, out_op0_q, out_op0_d, out_op1_q, out_op1_d;
    logic [RADDR_W-1:0] out_waddr_q, out_waddr_d;
    logic [CTRL_W-1:0]  out_ctrl_q, out_ctrl_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_mux0 (
        .re_i(bus.in_rs0_re), .addr_i(bus.in_rs0_addr), .rf_data_i(bus.rf_data0), .alt_data_i(bus.in_pc),
        .fwd_we_i(bus.fwd_we), .fwd_pending_i(bus.fwd_pending), .fwd_waddr_i(bus.fwd_waddr),
        .fwd_wdata_i(bus.fwd_wdata), .data_o(op0), .hazard_o(haz0)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_mux1 (
        .re_i(bus.in_rs1_re), .addr_i(bus.in_rs1_addr), .rf_data_i(bus.rf_data1), .alt_data_i(bus.in_imm),
        .fwd_we_i(bus.fwd_we), .fwd_pending_i(bus.fwd_pending), .fwd_waddr_i(bus.fwd_waddr),
        .fwd_wdata_i(bus.fwd_wdata), .data_o(op1), .hazard_o(haz1)
    );

    // in_ready deliberately ignores in_valid so upstream never sees a combinational loop
    assign hazard    = haz0 | haz1;
    assign in_ready  = ~bus.flush & ~hazard & (~out_valid_q | bus.out_ready);
    assign fire      = bus.in_valid & in_ready;
    assign stall_req = bus.in_valid & hazard & ~bus.flush;

    // Next state: flush kills, fire loads, drained slot becomes a bubble, backpressure holds
    always_comb begin
        out_valid_d   = bus.flush ? 1'b0 : fire ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
        out_pc_d      = fire ? bus.in_pc      : out_pc_q;
        out_op0_d     = fire ? op0            : out_op0_q;
        out_op1_d     = fire ? op1            : out_op1_q;
        out_we_d      = fire ? bus.in_we      : out_we_q;
        out_is_load_d = fire ? bus.in_is_load : out_is_load_q;
        out_waddr_d   = fire ? bus.in_waddr   : out_waddr_q;
        out_ctrl_d    = fire ? bus.in_ctrl    : out_ctrl_q;
        stall_cnt_d   = (stall_req && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // ID/EX register and saturating stall counter, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            out_valid_q   <= 1'b0;
            out_we_q      <= 1'b0;
            out_is_load_q <= 1'b0;
            out_pc_q      <= DATA_W'(ZeroWord);
            out_op0_q     <= DATA_W'(ZeroWord);
            out_op1_q     <= DATA_W'(ZeroWord);
            out_waddr_q   <= '0;
            out_ctrl_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_we_q      <= out_we_d;
            out_is_load_q <= out_is_load_d;
            out_pc_q      <= out_pc_d;
            out_op0_q     <= out_op0_d;
            out_op1_q     <= out_op1_d;
            out_waddr_q   <= out_waddr_d;
            out_ctrl_q    <= out_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.stall_req   = stall_req;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_op0     = out_op0_q;
    assign bus.out_op1     = out_op1_q;
    assign bus.out_we      = out_we_q;
    assign bus.out_is_load = out_is_load_q;
    assign bus.out_waddr   = out_waddr_q;
    assign bus.out_ctrl    = out_ctrl_q;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_id_hazard_stage.sv
// tb_id_hazard_stage: directed plus random scoreboard bench for the decode-operand hazard stage
module tb_id_hazard_stage;
    localparam int DW = 16, AW = 4, CW = 8, NF = 2, CNTW = 4;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [DW-1:0] op0;
        logic [DW-1:0] op1;
        logic          we;
        logic          ld;
        logic [AW-1:0] waddr;
        logic [CW-1:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_hazard_stage_if #(.DATA_W(DW), .RADDR_W(AW), .CTRL_W(CW), .NUM_FWD(NF), .CNT_W(CNTW)) bus ();
    id_hazard_stage #(.DATA_W(DW), .RADDR_W(AW), .CTRL_W(CW), .NUM_FWD(NF), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t exp_q[$];
    int   errors = 0, checks = 0;
    bit   cur_valid = 1'b0;
    int   cur_cnt = 0;
    bit   obs_rdy, obs_sreq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand: first (youngest) enabled source naming the register wins; else RF; disabled reads take alt
    function automatic logic [DW-1:0] resolve(input logic re, input logic [AW-1:0] a,
                                              input logic [DW-1:0] rf, input logic [DW-1:0] alt,
                                              output bit haz);
        logic [AW-1:0] fa;
        haz = 1'b0;
        if (!re) return alt;
        for (int i = 0; i < NF; i++) begin
            fa = bus.fwd_waddr[i*AW +: AW];
            if (bus.fwd_we[i] && fa == a) begin
                haz = bus.fwd_pending[i];
                return bus.fwd_wdata[i*DW +: DW];
            end
        end
        return rf;
    endfunction

    task automatic idle();
        bus.in_valid = 0; bus.in_rs0_re = 0; bus.in_rs1_re = 0;
        bus.in_rs0_addr = 0; bus.in_rs1_addr = 0; bus.rf_data0 = 0; bus.rf_data1 = 0;
        bus.in_pc = 0; bus.in_imm = 0; bus.in_we = 0; bus.in_waddr = 0; bus.in_is_load = 0;
        bus.in_ctrl = 0; bus.fwd_we = 0; bus.fwd_pending = 0; bus.fwd_waddr = 0;
        bus.fwd_wdata = 0; bus.flush = 0; bus.out_ready = 1;
    endtask

    // Called at posedge+1 with inputs applied; predicts handshake, queues expected output, advances one cycle
    task automatic step();
        bit h0, h1, haz, rdy, sreq, fire, nv;
        int nc;
        exp_t e;
        e.op0   = resolve(bus.in_rs0_re, bus.in_rs0_addr, bus.rf_data0, bus.in_pc, h0);
        e.op1   = resolve(bus.in_rs1_re, bus.in_rs1_addr, bus.rf_data1, bus.in_imm, h1);
        e.pc    = bus.in_pc;
        e.we    = bus.in_we;
        e.ld    = bus.in_is_load;
        e.waddr = bus.in_waddr;
        e.ctrl  = bus.in_ctrl;
        haz  = h0 | h1;
        rdy  = !bus.flush && !haz && (!cur_valid || bus.out_ready);
        sreq = bus.in_valid && haz && !bus.flush;
        fire = bus.in_valid && rdy;
        #3;
        obs_rdy  = bus.in_ready;
        obs_sreq = bus.stall_req;
        chk("in_ready", bus.in_ready, rdy);
        chk("stall_req", bus.stall_req, sreq);
        if (bus.flush && cur_valid) exp_q.delete(0);
        if (fire) exp_q.push_back(e);
        nv = bus.flush ? 1'b0 : fire ? 1'b1 : bus.out_ready ? 1'b0 : cur_valid;
        nc = (sreq && cur_cnt < 2**CNTW - 1) ? cur_cnt + 1 : cur_cnt;
        @(posedge clk);
        #1;
        cur_valid = nv;
        cur_cnt   = nc;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_pc"}, bus.out_pc, 0);
        chk({tag, "_op0"}, bus.out_op0, 0);
        chk({tag, "_op1"}, bus.out_op1, 0);
        chk({tag, "_we"}, bus.out_we, 0);
        chk({tag, "_ld"}, bus.out_is_load, 0);
        chk({tag, "_waddr"}, bus.out_waddr, 0);
        chk({tag, "_ctrl"}, bus.out_ctrl, 0);
        chk({tag, "_cnt"}, bus.stall_cnt, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock edge
    task automatic rst_mid();
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        cur_valid = 1'b0;
        cur_cnt   = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares ID/EX state every cycle and consumes one expected entry per EX transfer
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            chk("out_valid", bus.out_valid, cur_valid);
            chk("stall_cnt", bus.stall_cnt, cur_cnt);
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer: got an output with nothing expected at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_op0", bus.out_op0, e.op0);
                    chk("out_op1", bus.out_op1, e.op1);
                    chk("out_we", bus.out_we, e.we);
                    chk("out_is_load", bus.out_is_load, e.ld);
                    chk("out_waddr", bus.out_waddr, e.waddr);
                    chk("out_ctrl", bus.out_ctrl, e.ctrl);
                end
            end
        end
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Youngest source wins over older source naming the same register
        bus.in_valid = 1; bus.in_rs0_re = 1; bus.in_rs0_addr = 3; bus.rf_data0 = 16'h5555;
        bus.in_pc = 16'h0010; bus.in_imm = 16'h0007;
        bus.fwd_we = 2'b11; bus.fwd_waddr = {4'd3, 4'd3}; bus.fwd_wdata = {16'h2222, 16'h1111};
        step();
        chk("fwd_prio_op0", bus.out_op0, 16'h1111);

        // Start a load-use stall, then reset in the middle of it
        bus.in_rs0_re = 0; bus.in_rs1_re = 1; bus.in_rs1_addr = 5; bus.rf_data1 = 16'h0101;
        bus.fwd_we = 2'b01; bus.fwd_pending = 2'b01; bus.fwd_waddr = {4'd0, 4'd5};
        bus.fwd_wdata = {16'h0000, 16'hDEAD};
        step();
        step();
        chk("stall_cnt_pre_rst", bus.stall_cnt, 2);
        rst_mid();

        // Load-use: two stalled cycles, then accept with the now-available load data
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lu_stall_req", obs_sreq, 1);
            chk("lu_in_ready", obs_rdy, 0);
            chk("lu_out_valid", bus.out_valid, 0);
        end
        bus.fwd_pending = 2'b00; bus.fwd_wdata = {16'h0000, 16'hBEEF};
        step();
        chk("lu_in_ready_release", obs_rdy, 1);
        chk("lu_op1", bus.out_op1, 16'hBEEF);
        chk("lu_stall_cnt", bus.stall_cnt, 2);

        // PC and immediate paths ignore forwarding entirely
        idle();
        bus.in_valid = 1; bus.in_pc = 16'h0040; bus.in_imm = 16'hFFF8;
        bus.fwd_we = 2'b11; bus.fwd_pending = 2'b11; bus.fwd_wdata = {16'h3333, 16'h4444};
        step();
        chk("imm_in_ready", obs_rdy, 1);
        chk("pc_op0", bus.out_op0, 16'h0040);
        chk("imm_op1", bus.out_op1, 16'hFFF8);

        // Backpressure holds ID/EX; release accepts the waiting instruction the same cycle
        idle();
        bus.in_valid = 1; bus.in_pc = 16'h0100;
        step();
        bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            bus.in_pc = 16'h0200 + 16'(i);
            step();
            chk("bp_in_ready", obs_rdy, 0);
            chk("bp_pc_stable", bus.out_pc, 16'h0100);
        end
        bus.out_ready = 1; bus.in_pc = 16'h0300;
        step();
        chk("bp_release_ready", obs_rdy, 1);
        chk("bp_release_pc", bus.out_pc, 16'h0300);

        // Flush beats a fireable instruction and kills the ID/EX entry
        bus.flush = 1; bus.in_pc = 16'h0400;
        step();
        chk("flush_in_ready", obs_rdy, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        bus.flush = 0;

        // Counter saturates under a long-held hazard
        idle();
        bus.in_valid = 1; bus.in_rs0_re = 1; bus.in_rs0_addr = 7;
        bus.fwd_we = 2'b10; bus.fwd_pending = 2'b10; bus.fwd_waddr = {4'd7, 4'd0};
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt", bus.stall_cnt, 15);

        // Random traffic, small address space so forwarding collisions are frequent
        for (int n = 0; n < 1500; n++) begin
            bus.in_valid    = $urandom_range(0, 9) < 8;
            bus.in_rs0_re   = 1'($urandom);
            bus.in_rs1_re   = 1'($urandom);
            bus.in_rs0_addr = AW'($urandom_range(0, 3));
            bus.in_rs1_addr = AW'($urandom_range(0, 3));
            bus.rf_data0    = DW'($urandom);
            bus.rf_data1    = DW'($urandom);
            bus.in_pc       = DW'($urandom);
            bus.in_imm      = DW'($urandom);
            bus.in_we       = 1'($urandom);
            bus.in_waddr    = AW'($urandom);
            bus.in_is_load  = 1'($urandom);
            bus.in_ctrl     = CW'($urandom);
            for (int i = 0; i < NF; i++) begin
                bus.fwd_we[i]               = 1'($urandom);
                bus.fwd_pending[i]          = $urandom_range(0, 3) == 0;
                bus.fwd_waddr[i*AW +: AW]   = AW'($urandom_range(0, 3));
                bus.fwd_wdata[i*DW +: DW]   = DW'($urandom);
            end
            bus.flush     = $urandom_range(0, 15) == 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 299) == 0) rst_mid();
            else step();
        end

        idle();
        for (int i = 0; i < 3; i++) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
